// File: rtl/io_port_unit.sv
// Port-I/O responder for PIN/POUT: buffered output FIFO plus a request/valid input handshake.
// Define IO_ORDER_FENCE_EN to hold each PIN until every earlier POUT has left the FIFO.
module io_port_unit #(
  parameter int unsigned DW       = 32,
  parameter int unsigned NPORT    = 4,
  parameter int unsigned OF_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pin_en,
  input  logic                     pout_en,
  input  logic [31:0]              addr,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     stall,
  output logic                     io_err,
  output logic                     out_valid,
  output logic [$clog2(NPORT)-1:0] out_port,
  output logic [DW-1:0]            out_data,
  input  logic                     out_ready,
  output logic                     in_req,
  output logic [$clog2(NPORT)-1:0] in_port,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data
);

  localparam int unsigned PW = $clog2(NPORT);
  localparam int unsigned AW = $clog2(OF_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   in_port_q, in_port_d;
  logic            in_req_q, in_req_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            io_err_q, io_err_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            out_valid_q, out_valid_d;
  logic [PW-1:0]   port_mem_q [OF_DEPTH];
  logic [PW-1:0]   port_mem_d [OF_DEPTH];
  logic [DW-1:0]   data_mem_q [OF_DEPTH];
  logic [DW-1:0]   data_mem_d [OF_DEPTH];

  logic            fifo_full;
  logic            fence_ok;
  logic            push;
  logic            pop;
  logic            stall_c;
  logic            unused_addr;

  assign unused_addr = ^addr[31:PW];

  assign fifo_full = (count_q == CW'(OF_DEPTH));
  assign pop       = out_valid_q && out_ready;

`ifdef IO_ORDER_FENCE_EN
  assign fence_ok = (count_q == '0);
`else
  assign fence_ok = 1'b1;
`endif

  // PIN handshake FSM, POUT acceptance and stall generation
  always_comb begin
    state_d   = state_q;
    in_port_d = in_port_q;
    rdata_d   = rdata_q;
    io_err_d  = io_err_q;
    push      = 1'b0;
    stall_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pin_en && pout_en) begin
          io_err_d = 1'b1;
        end else if (pin_en) begin
          stall_c   = 1'b1;
          in_port_d = addr[PW-1:0];
          if (fence_ok) begin
            state_d = ST_REQ;
          end
        end else if (pout_en) begin
          if (fifo_full) begin
            stall_c = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
      end
      ST_REQ: begin
        stall_c = 1'b1;
        if (pout_en) begin
          io_err_d = 1'b1;
        end
        if (in_valid) begin
          rdata_d = in_data;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (pout_en) begin
          io_err_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (rst) begin
      stall_c = 1'b0;
    end
    in_req_d = (state_d == ST_REQ);
  end

  // Output FIFO bookkeeping; a same-cycle pop never makes room for a push
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    port_mem_d = port_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      port_mem_d[wr_ptr_q] = addr[PW-1:0];
      data_mem_d[wr_ptr_q] = wdata;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    out_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_port_q   <= '0;
      in_req_q    <= 1'b0;
      rdata_q     <= '0;
      io_err_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < int'(OF_DEPTH); i++) begin
        port_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_port_q   <= in_port_d;
      in_req_q    <= in_req_d;
      rdata_q     <= rdata_d;
      io_err_q    <= io_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      port_mem_q  <= port_mem_d;
      data_mem_q  <= data_mem_d;
    end
  end

  assign stall     = stall_c;
  assign rdata     = rdata_q;
  assign io_err    = io_err_q;
  assign in_req    = in_req_q;
  assign in_port   = in_port_q;
  assign out_valid = out_valid_q;
  assign out_port  = port_mem_q[rd_ptr_q];
  assign out_data  = data_mem_q[rd_ptr_q];

endmodule
